colors_to_bytes: RTL and testbench

Converts a stream of 12-bit colors back into a bytestream, packing every two colors (24 bits) into three bytes, MSB first. It is the inverse of the byte-to-color packer on the video-memory path. It sits between the color/pixel readback stream and byte-oriented consumers such as the packet buffer writer and the encryption byte stream. Downstream backpressure is handled with a 2-byte output queue and a `rdy` handshake toward upstream.

---
 rtl/colors_to_bytes.sv | 110 +++++++++++
 tb/tb_colors_to_bytes.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/colors_to_bytes.sv
// Packs pairs of 12-bit colors into three bytes, MSB first, behind a 2-byte output queue.
// Optional odd-color flush with PAD_NIBBLE: define COLORS_TO_BYTES_FLUSH_EN.
module colors_to_bytes #(
    parameter logic [3:0] PAD_NIBBLE = 4'h0,
    localparam int unsigned COLOR_LEN = 12,
    localparam int unsigned BYTE_LEN  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inclk,
    input  logic [COLOR_LEN-1:0] in,
    input  logic                 in_done,
    input  logic                 downstream_rdy,
    output logic                 rdy,
    output logic                 outclk,
    output logic [BYTE_LEN-1:0]  out,
    output logic                 done,
    output logic                 overflow
);

    typedef enum logic {
        PH_A,
        PH_B
    } phase_t;

    phase_t              r_phase;
    logic [3:0]          r_nibble;
    logic [BYTE_LEN-1:0] r_byte0;
    logic [BYTE_LEN-1:0] r_byte1;
    logic                r_last0;
    logic                r_last1;
    logic [1:0]          r_count;
    logic                r_overflow;

    logic w_empty;
    logic w_accept;
    logic w_pop;

`ifndef COLORS_TO_BYTES_FLUSH_EN
    logic w_unused_pad;
    assign w_unused_pad = ^PAD_NIBBLE;
`endif

    assign w_empty  = (r_count == 2'd0);
    assign w_accept = inclk && w_empty;
    assign w_pop    = !w_empty && downstream_rdy;

    assign rdy      = w_empty;
    assign outclk   = w_pop;
    assign out      = w_empty ? '0 : r_byte0;
    assign done     = w_pop && r_last0;
    assign overflow = r_overflow;

    // Accept and pop are mutually exclusive: accept needs an empty queue, pop a non-empty one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase    <= PH_A;
            r_nibble   <= '0;
            r_byte0    <= '0;
            r_byte1    <= '0;
            r_last0    <= 1'b0;
            r_last1    <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (inclk && !w_empty) begin
                r_overflow <= 1'b1;
            end

            if (w_accept) begin
                if (r_phase == PH_A) begin
                    r_byte0 <= in[11:4];
                    if (in_done) begin
`ifdef COLORS_TO_BYTES_FLUSH_EN
                        r_byte1 <= {in[3:0], PAD_NIBBLE};
                        r_last0 <= 1'b0;
                        r_last1 <= 1'b1;
                        r_count <= 2'd2;
`else
                        r_last0 <= 1'b1;
                        r_count <= 2'd1;
`endif
                        r_nibble <= '0;
                        r_phase  <= PH_A;
                    end else begin
                        r_last0  <= 1'b0;
                        r_count  <= 2'd1;
                        r_nibble <= in[3:0];
                        r_phase  <= PH_B;
                    end
                end else begin
                    r_byte0 <= {r_nibble, in[11:8]};
                    r_byte1 <= in[7:0];
                    r_last0 <= 1'b0;
                    r_last1 <= in_done;
                    r_count <= 2'd2;
                    r_phase <= PH_A;
                    if (in_done) begin
                        r_nibble <= '0;
                    end
                end
            end else if (w_pop) begin
                r_byte0 <= r_byte1;
                r_last0 <= r_last1;
                r_count <= r_count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_colors_to_bytes.sv
// Randomized and directed bench for colors_to_bytes against a bit-accumulator reference model.
module tb_colors_to_bytes;

    localparam logic [3:0] PAD = 4'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        inclk;
    logic [11:0] in_c;
    logic        in_done;
    logic        downstream_rdy;
    logic        rdy;
    logic        outclk;
    logic [7:0]  out;
    logic        done;
    logic        overflow;

    colors_to_bytes #(.PAD_NIBBLE(PAD)) dut (
        .clk            (clk),
        .rst            (rst),
        .inclk          (inclk),
        .in             (in_c),
        .in_done        (in_done),
        .downstream_rdy (downstream_rdy),
        .rdy            (rdy),
        .outclk         (outclk),
        .out            (out),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes produced but not yet consumed, each {last, byte}.
    logic [8:0] mq[$];
    int         acc;
    int         nbits;
    logic       ovf_exp;
    logic [7:0] got_log[$];
    int         dr_mode;
    int         tog;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        acc     = 0;
        nbits   = 0;
        ovf_exp = 1'b0;
    endtask

    task automatic model_accept(input logic [11:0] c, input logic d);
        logic [8:0] t;
        acc   = ((acc << 12) | int'(c)) & 32'h00FF_FFFF;
        nbits = nbits + 12;
        while (nbits >= 8) begin
            mq.push_back({1'b0, 8'((acc >> (nbits - 8)) & 8'hFF)});
            nbits = nbits - 8;
        end
        if (d) begin
`ifdef COLORS_TO_BYTES_FLUSH_EN
            if (nbits == 4) mq.push_back({1'b0, 4'(acc & 15), PAD});
`endif
            nbits = 0;
            t = mq.pop_back();
            t[8] = 1'b1;
            mq.push_back(t);
        end
    endtask

    task automatic step(input logic ic, input logic [11:0] c, input logic d);
        logic dr;
        logic was_empty;
        case (dr_mode)
            0: dr = 1'b1;
            1: begin
                dr  = (tog % 3 == 0);
                tog = tog + 1;
            end
            default: dr = ($urandom_range(0, 9) < 7);
        endcase
        @(posedge clk);
        #1;
        inclk          = ic;
        in_c           = c;
        in_done        = d;
        downstream_rdy = dr;
        @(negedge clk);
        was_empty = (mq.size() == 0);
        check("rdy", rdy, was_empty);
        check("outclk", outclk, !was_empty && dr);
        check("overflow", overflow, ovf_exp);
        if (!was_empty) begin
            check("out", out, mq[0][7:0]);
            if (dr) begin
                check("done", done, mq[0][8]);
                got_log.push_back(out);
            end else begin
                check("done_stall", done, 0);
            end
        end else begin
            check("out_empty", out, 0);
            check("done_empty", done, 0);
        end
        if (ic && !was_empty) ovf_exp = 1'b1;
        if (!was_empty && dr) void'(mq.pop_front());
        else if (ic && was_empty) model_accept(c, d);
    endtask

    task automatic send(input logic [11:0] c, input logic d);
        int n = 0;
        while (mq.size() != 0 && n < 50) begin
            step(1'b0, 12'h000, 1'b0);
            n++;
        end
        if (n == 50) check("rdy_timeout", rdy, 1);
        step(1'b1, c, d);
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() != 0 && n < 50) begin
            step(1'b0, 12'h000, 1'b0);
            n++;
        end
        if (n == 50) check("drain_timeout", rdy, 1);
        step(1'b0, 12'h000, 1'b0);
    endtask

    task automatic check_seq(input string tag, input int n, input logic [7:0] e[8]);
        check({tag, "_len"}, got_log.size(), n);
        for (int i = 0; i < n && i < got_log.size(); i++) begin
            check(tag, got_log[i], e[i]);
        end
        got_log.delete();
    endtask

    initial begin
        rst            = 1'b1;
        inclk          = 1'b0;
        in_c           = '0;
        in_done        = 1'b0;
        downstream_rdy = 1'b1;
        dr_mode        = 0;
        tog            = 0;
        model_reset();
        #12;
        check("rst_rdy", rdy, 1);
        check("rst_outclk", outclk, 0);
        check("rst_out", out, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // Pair packing with downstream always ready
        send(12'hABC, 1'b0);
        send(12'hDEF, 1'b0);
        drain();
        check_seq("pair", 3, '{8'hAB, 8'hCD, 8'hEF, 0, 0, 0, 0, 0});

        // Backpressure pattern 1,0,0,...
        dr_mode = 1;
        send(12'hABC, 1'b0);
        send(12'hDEF, 1'b0);
        drain();
        check_seq("bp", 3, '{8'hAB, 8'hCD, 8'hEF, 0, 0, 0, 0, 0});
        dr_mode = 0;

        // Even-length stream with done, then phase is back at A
        send(12'h123, 1'b0);
        send(12'h456, 1'b1);
        send(12'h789, 1'b0);
        send(12'hABC, 1'b1);
        drain();
        check_seq("even", 6, '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 0, 0});

        // Odd final color
        send(12'h9F1, 1'b1);
        drain();
`ifdef COLORS_TO_BYTES_FLUSH_EN
        check_seq("odd", 2, '{8'h9F, 8'h10, 0, 0, 0, 0, 0, 0});
`else
        check_seq("odd", 1, '{8'h9F, 0, 0, 0, 0, 0, 0, 0});
`endif

        // Violation while one byte is queued
        send(12'hABC, 1'b0);
        step(1'b1, 12'hFFF, 1'b0);
        send(12'hDEF, 1'b0);
        drain();
        check_seq("viol", 3, '{8'hAB, 8'hCD, 8'hEF, 0, 0, 0, 0, 0});
        check("viol_sticky", overflow, 1);

        // Randomized traffic
        dr_mode = 2;
        for (int i = 0; i < 600; i++) begin
            logic ic;
            ic = (mq.size() == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 59) == 0);
            step(ic, 12'($urandom), ($urandom_range(0, 7) == 0));
        end
        drain();
        got_log.delete();

        // Async reset between the two bytes of a phase-B color
        dr_mode = 0;
        send(12'hABC, 1'b0);
        send(12'hDEF, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_outclk", outclk, 0);
        check("arst_out", out, 0);
        check("arst_done", done, 0);
        check("arst_rdy", rdy, 1);
        check("arst_ovf", overflow, 0);
        #1;
        rst = 1'b0;
        model_reset();
        got_log.delete();
        send(12'hABC, 1'b0);
        send(12'hDEF, 1'b0);
        drain();
        check_seq("post_rst", 3, '{8'hAB, 8'hCD, 8'hEF, 0, 0, 0, 0, 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
